// File: rtl/reg_writeback_unit_if.sv
// -----------------------------------------------------------------------------
// reg_writeback_unit_if
//   Bundle of every bus and handshake signal around reg_writeback_unit.
//   master : issue/decode, execute and memory stages (drive requests, see status)
//   slave  : reg_writeback_unit (sees requests, drives hazard/ready/write port)
// Signals
//   iss_valid/iss_rd    issue of an instruction with a destination register
//   rs1/rs2             sources of the instruction sitting in decode
//   hazard              decode must stall
//   alu_valid/rd/data   ALU result offer, accepted with alu_ready
//   ld_valid/rd/data    load result, never back-pressured
//   WE3/A3/WD3          register-file write port
//   pending             ALU queue occupancy
// -----------------------------------------------------------------------------
interface reg_writeback_unit_if #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int FIFO_DEPTH = 4
);
  logic                          iss_valid;
  logic [AW-1:0]                 iss_rd;
  logic [AW-1:0]                 rs1;
  logic [AW-1:0]                 rs2;
  logic                          hazard;
  logic                          alu_valid;
  logic [AW-1:0]                 alu_rd;
  logic [XLEN-1:0]               alu_data;
  logic                          alu_ready;
  logic                          ld_valid;
  logic [AW-1:0]                 ld_rd;
  logic [XLEN-1:0]               ld_data;
  logic                          WE3;
  logic [AW-1:0]                 A3;
  logic [XLEN-1:0]               WD3;
  logic [$clog2(FIFO_DEPTH):0]   pending;

  modport master (
    output iss_valid, iss_rd, rs1, rs2,
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    input  hazard, alu_ready, WE3, A3, WD3, pending
  );

  modport slave (
    input  iss_valid, iss_rd, rs1, rs2,
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    output hazard, alu_ready, WE3, A3, WD3, pending
  );
endinterface

// File: rtl/reg_writeback_unit.sv
// -----------------------------------------------------------------------------
// reg_writeback_unit
//   Write-side companion of the register file. Merges load results and queued
//   ALU results onto the single write port (WE3/A3/WD3), keeps a busy
//   scoreboard of issued-but-unwritten destinations and raises hazard for
//   RAW/WAW conflicts.
// Ports
//   clk  rising-edge clock
//   rst  synchronous reset, active-high
//   bus  reg_writeback_unit_if.slave (issue, decode sources, ALU and load
//        result buses, write port, hazard, alu_ready, pending)
// -----------------------------------------------------------------------------
module reg_writeback_unit #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_writeback_unit_if.slave  bus
);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int NREG = 2 ** AW;

  // One-hot decode of a register index, gated by an enable.
  function automatic logic [NREG-1:0] reg_mask(input logic [AW-1:0] idx, input logic en);
    logic [NREG-1:0] one;
    one = {{(NREG-1){1'b0}}, 1'b1};
    return en ? (one << idx) : {NREG{1'b0}};
  endfunction

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [AW-1:0]   q_rd   [FIFO_DEPTH];
  logic [XLEN-1:0] q_data [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic [PW:0]     count_next;
  logic            alu_ready;
  logic            push;
  logic            pop;
  logic            sel_valid;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            we;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wd;

  assign alu_ready = (count != (PW+1)'(FIFO_DEPTH));
  assign push      = bus.alu_valid & alu_ready;
  // The queue head only moves when no load claims the write port.
  assign pop       = ~bus.ld_valid & (count != {(PW+1){1'b0}});

  // Hazard looks at registered busy only: a register being written this cycle still stalls.
  assign bus.hazard    = busy[bus.rs1] | busy[bus.rs2] | (bus.iss_valid & busy[bus.iss_rd]);
  assign bus.alu_ready = alu_ready;
  assign bus.pending   = count;
  assign bus.WE3       = we;
  assign bus.A3        = wa;
  assign bus.WD3       = wd;

  // Scoreboard next state: clear the committed register, then set the issued one so set wins.
  always_comb begin
    busy_next    = (busy & ~reg_mask(wa, we)) | reg_mask(bus.iss_rd, bus.iss_valid);
    busy_next[0] = 1'b0;
  end

  // Write-port arbitration: load first, then queue head.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = {AW{1'b0}};
    sel_data  = {XLEN{1'b0}};
    if (bus.ld_valid) begin
      sel_valid = 1'b1;
      sel_rd    = bus.ld_rd;
      sel_data  = bus.ld_data;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_rd    = q_rd[rd_ptr];
      sel_data  = q_data[rd_ptr];
    end else begin
      sel_valid = 1'b0;
    end
  end

  // Queue occupancy update; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (PW+1)'(1);
      2'b01:   count_next = count - (PW+1)'(1);
      default: count_next = count;
    endcase
  end

  // Queue payload storage; contents are meaningless until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= bus.alu_rd;
      q_data[wr_ptr] <= bus.alu_data;
    end
  end

  // Control state, scoreboard and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= {(PW+1){1'b0}};
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      busy   <= {NREG{1'b0}};
      we     <= 1'b0;
      wa     <= {AW{1'b0}};
      wd     <= {XLEN{1'b0}};
    end else begin
      count <= count_next;
      busy  <= busy_next;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      // An rd==0 selection is consumed but never written; A3/WD3 keep their last values.
      we <= sel_valid & (sel_rd != {AW{1'b0}});
      if (sel_valid && (sel_rd != {AW{1'b0}})) begin
        wa <= sel_rd;
        wd <= sel_data;
      end
    end
  end
endmodule

// File: tb/tb_reg_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_reg_writeback_unit
//   Directed scenarios plus randomized traffic against a reference model built
//   from a result queue, a busy array and the expected write-port registers.
// -----------------------------------------------------------------------------
module tb_reg_writeback_unit;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int FD   = 4;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_writeback_unit_if #(.XLEN(XLEN), .AW(AW), .FIFO_DEPTH(FD)) bus ();
  reg_writeback_unit #(.XLEN(XLEN), .AW(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  ent_t            q[$];
  bit              busy_m[2**AW];
  logic            exp_we;
  logic [AW-1:0]   exp_a3;
  logic [XLEN-1:0] exp_wd;
  bit              last_acc;
  int              n_checks = 0;
  int              n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit model_hazard();
    return busy_m[bus.rs1] || busy_m[bus.rs2] || (bus.iss_valid && busy_m[bus.iss_rd]);
  endfunction

  task automatic model_reset();
    q.delete();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    exp_we = 1'b0;
    exp_a3 = '0;
    exp_wd = '0;
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
  endtask

  // Called at posedge+1 with inputs set: checks combinational outputs before the
  // edge, advances the model, then checks the registered write port after it.
  task automatic step();
    bit   sel;
    bit   acc;
    ent_t s;
    #3;
    chk("hazard", bus.hazard, model_hazard());
    chk("alu_ready", bus.alu_ready, q.size() != FD);
    chk("pending", bus.pending, q.size());
    if (rst) begin
      model_reset();
      last_acc = 1'b0;
    end else begin
      acc = bus.alu_valid && (q.size() != FD);
      last_acc = acc;
      sel = 1'b0;
      s   = '0;
      if (bus.ld_valid) begin
        sel = 1'b1; s.rd = bus.ld_rd; s.data = bus.ld_data;
      end else if (q.size() > 0) begin
        sel = 1'b1; s = q.pop_front();
      end
      if (acc) q.push_back({bus.alu_rd, bus.alu_data});
      if (exp_we) busy_m[exp_a3] = 1'b0;
      if (bus.iss_valid && bus.iss_rd != 0) busy_m[bus.iss_rd] = 1'b1;
      if (sel && s.rd != 0) begin
        exp_we = 1'b1; exp_a3 = s.rd; exp_wd = s.data;
      end else begin
        exp_we = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("WE3", bus.WE3, exp_we);
    chk("A3", bus.A3, exp_a3);
    chk("WD3", bus.WD3, exp_wd);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    last_acc = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    // Single ALU write with hazard until the commit has been seen.
    idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd5; step();
    idle(); bus.rs1 = 5'd5; bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h0000000A;
    #2 chk("t2_haz_busy", bus.hazard, 1'b1); step();
    idle(); bus.rs1 = 5'd5; step();
    chk("t2_we", bus.WE3, 1'b1); chk("t2_a3", bus.A3, 5'd5); chk("t2_wd", bus.WD3, 32'h0000000A);
    idle(); bus.rs1 = 5'd5;
    #2 chk("t2_haz_during_write", bus.hazard, 1'b1); step();
    idle(); bus.rs1 = 5'd5;
    #2 chk("t2_haz_cleared", bus.hazard, 1'b0); step();

    // Load and ALU in the same cycle: load first.
    idle(); bus.ld_valid = 1'b1; bus.ld_rd = 5'd6; bus.ld_data = 32'h0000000B;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h0000000C; step();
    chk("t3_a3_first", bus.A3, 5'd6); chk("t3_wd_first", bus.WD3, 32'h0000000B);
    chk("t3_pending_peak", bus.pending, 1);
    idle(); step();
    chk("t3_a3_second", bus.A3, 5'd7); chk("t3_wd_second", bus.WD3, 32'h0000000C);
    idle(); step();

    // Fill the queue behind a continuous load stream, then drain in order.
    for (int i = 0; i < 4; i++) begin
      idle(); bus.ld_valid = 1'b1; bus.ld_rd = AW'(10 + i); bus.ld_data = $urandom;
      bus.alu_valid = 1'b1; bus.alu_rd = AW'(16 + i); bus.alu_data = $urandom;
      step();
    end
    chk("t4_pending_full", bus.pending, 4);
    chk("t4_ready_low", bus.alu_ready, 1'b0);
    bus.ld_rd = 5'd14; bus.alu_rd = 5'd20; bus.alu_data = 32'h55AA0020; step();
    chk("t4_fifth_held", bus.pending, 4);
    bus.ld_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_order", bus.A3, 16 + k);
      if (k == 1) bus.alu_valid = 1'b0;
    end
    idle(); step();

    // x0 destination: never busy, never written, still consumed.
    idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    #2 chk("t5_haz_x0", bus.hazard, 1'b0); step();
    idle(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFFFFFF; step();
    idle(); step();
    chk("t5_we_x0", bus.WE3, 1'b0); chk("t5_consumed", bus.pending, 0);
    step();

    // Same-edge commit and re-issue of x9: set wins.
    idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd9; step();
    idle(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h00000099; step();
    idle(); step();
    chk("t6_commit_a3", bus.A3, 5'd9);
    idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd9; step();
    idle(); bus.rs2 = 5'd9;
    #2 chk("t6_haz_rs2", bus.hazard, 1'b1); step();

    // Randomized traffic with a two-cycle reset in the middle.
    for (int c = 0; c < 400; c++) begin
      rst = (c == 200 || c == 201);
      bus.iss_valid = ($urandom_range(0, 3) == 0);
      bus.iss_rd    = AW'($urandom_range(0, 7));
      bus.rs1       = AW'($urandom_range(0, 7));
      bus.rs2       = AW'($urandom_range(0, 7));
      if (!(bus.alu_valid && !last_acc)) begin
        bus.alu_valid = ($urandom_range(0, 1) == 1);
        bus.alu_rd    = AW'($urandom_range(0, 7));
        bus.alu_data  = $urandom;
      end
      bus.ld_valid = ($urandom_range(0, 2) == 0);
      bus.ld_rd    = AW'($urandom_range(0, 7));
      bus.ld_data  = $urandom;
      step();
      if (c == 201) begin
        rst = 1'b0;
        chk("t1_we", bus.WE3, 1'b0); chk("t1_a3", bus.A3, 5'd0); chk("t1_wd", bus.WD3, 32'd0);
        chk("t1_pending", bus.pending, 0); chk("t1_ready", bus.alu_ready, 1'b1);
        for (int r = 0; r < 3; r++) begin
          bus.rs1 = AW'(r * 3 + 1); bus.rs2 = AW'(r * 5 + 2); bus.iss_valid = 1'b1; bus.iss_rd = AW'(r + 4);
          #1 chk("t1_hazard", bus.hazard, 1'b0);
        end
      end
    end
    rst = 1'b0;
    idle();
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
